// File: rtl/electrode_cfg_serdes.sv
// electrode_cfg_serdes
//   Shifts N_CH parallel electrode configuration words out to N_CH
//   daisy-chained electrode registers over a shared divided shift clock,
//   capturing the returning bits of each chain as a readback word.
//   MSB-first (legacy) or LSB-first ordering.
//
// Ports
//   CLK, RST_N     system clock, asynchronous active-low reset
//   start          request a configuration cycle (sampled only in IDLE)
//   lsb_first      0: bit N_ELECTRODES-1 first, 1: bit 0 first
//   clk_div        sr_clk half-period in CLK cycles, minus 1
//   cfg_in         channel c at [c*N_ELECTRODES +: N_ELECTRODES]
//   serial_in      bit returning from the end of each chain
//   busy           high from LOAD through FINISH
//   enable_config  high while shifting
//   sr_clk         registered shift clock to the chains
//   serial_out     serial data per chain
//   readback       captured chain bits, same slicing as cfg_in
//   sr_finish      one-cycle completion pulse
module electrode_cfg_serdes #(
  parameter int unsigned N_ELECTRODES = 31,
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DIV_W        = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start,
  input  logic                         lsb_first,
  input  logic [DIV_W-1:0]             clk_div,
  input  logic [N_CH*N_ELECTRODES-1:0] cfg_in,
  input  logic [N_CH-1:0]              serial_in,
  output logic                         busy,
  output logic                         enable_config,
  output logic                         sr_clk,
  output logic [N_CH-1:0]              serial_out,
  output logic [N_CH*N_ELECTRODES-1:0] readback,
  output logic                         sr_finish
);

  localparam int unsigned   BW       = (N_ELECTRODES > 1) ? $clog2(N_ELECTRODES) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N_ELECTRODES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, FINISH} state_t;

  state_t                         state, next_state;
  logic [N_CH*N_ELECTRODES-1:0]   shreg;
  logic [DIV_W-1:0]               div_q;
  logic [DIV_W-1:0]               phase_cnt;
  logic [BW-1:0]                  bit_cnt;
  logic                           lsb_q;
  logic                           phase_done;

  logic                           busy_d, en_d, sr_clk_d, fin_d;
  logic                           enter_lo, enter_hi, enter_fin;
  logic [N_CH*N_ELECTRODES-1:0]   src, sh_d, rb_d;
  logic                           ord;
  logic [N_CH-1:0]                bit_d;

  assign phase_done = (phase_cnt == div_q);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = LOAD;
      LOAD:     next_state = SHIFT_LO;
      SHIFT_LO: if (phase_done) next_state = SHIFT_HI;
      SHIFT_HI: if (phase_done) next_state = (bit_cnt == LAST_BIT) ? FINISH : SHIFT_LO;
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs, taken from
  // next_state so every output changes on the edge that enters a state.
  always_comb begin
    busy_d    = (next_state != IDLE);
    en_d      = (next_state == SHIFT_LO) || (next_state == SHIFT_HI);
    sr_clk_d  = (next_state == SHIFT_HI);
    fin_d     = (next_state == FINISH);
    enter_lo  = (next_state == SHIFT_LO) && (state != SHIFT_LO);
    enter_hi  = (next_state == SHIFT_HI) && (state != SHIFT_HI);
    enter_fin = (next_state == FINISH)   && (state != FINISH);
  end

  // Per-channel shift/readback datapath. On the LOAD->SHIFT_LO edge the
  // first bit comes straight from cfg_in, so loading and the first shift
  // happen on the same edge.
  always_comb begin
    src   = (state == LOAD) ? cfg_in : shreg;
    ord   = (state == LOAD) ? lsb_first : lsb_q;
    sh_d  = '0;
    rb_d  = '0;
    bit_d = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ord) begin
        bit_d[c] = src[c*N_ELECTRODES];
        sh_d[c*N_ELECTRODES +: N_ELECTRODES] =
          {1'b0, src[c*N_ELECTRODES+1 +: N_ELECTRODES-1]};
      end else begin
        bit_d[c] = src[c*N_ELECTRODES+N_ELECTRODES-1];
        sh_d[c*N_ELECTRODES +: N_ELECTRODES] =
          {src[c*N_ELECTRODES +: N_ELECTRODES-1], 1'b0};
      end
      if (lsb_q)
        rb_d[c*N_ELECTRODES +: N_ELECTRODES] =
          {serial_in[c], readback[c*N_ELECTRODES+1 +: N_ELECTRODES-1]};
      else
        rb_d[c*N_ELECTRODES +: N_ELECTRODES] =
          {readback[c*N_ELECTRODES +: N_ELECTRODES-1], serial_in[c]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy          <= 1'b0;
      enable_config <= 1'b0;
      sr_clk        <= 1'b0;
      sr_finish     <= 1'b0;
      serial_out    <= '0;
      readback      <= '0;
      shreg         <= '0;
      div_q         <= '0;
      lsb_q         <= 1'b0;
      phase_cnt     <= '0;
      bit_cnt       <= '0;
    end else begin
      busy          <= busy_d;
      enable_config <= en_d;
      sr_clk        <= sr_clk_d;
      sr_finish     <= fin_d;

      if (state == LOAD) begin
        div_q    <= clk_div;
        lsb_q    <= lsb_first;
        readback <= '0;
      end

      if (enter_lo) begin
        serial_out <= bit_d;
        shreg      <= sh_d;
      end else if (enter_fin) begin
        serial_out <= '0;
      end

      if (enter_hi) readback <= rb_d;

      if (next_state != state)
        phase_cnt <= '0;
      else if ((state == SHIFT_LO) || (state == SHIFT_HI))
        phase_cnt <= phase_cnt + 1'b1;

      if (state == LOAD)
        bit_cnt <= '0;
      else if ((state == SHIFT_HI) && (next_state == SHIFT_LO))
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_electrode_cfg_serdes.sv
// tb_electrode_cfg_serdes
//   Directed testbench for electrode_cfg_serdes (N_ELECTRODES=31, N_CH=2).
//   Channel 1 is always looped back; channel 0 is looped back or driven by
//   a 31-bit chain model clocked by sr_clk.
module tb_electrode_cfg_serdes;

  localparam int NE = 31;
  localparam int NC = 2;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            start = 1'b0;
  logic            lsb_first = 1'b0;
  logic [3:0]      clk_div = '0;
  logic [NC*NE-1:0] cfg_in = '0;
  logic [NC-1:0]   serial_in;
  logic            busy, enable_config, sr_clk, sr_finish;
  logic [NC-1:0]   serial_out;
  logic [NC*NE-1:0] readback;

  logic            chain_mode = 1'b0;
  logic            chain_load = 1'b0;
  logic [NE-1:0]   chain_init = '0;
  logic [NE-1:0]   chain;

  int vectors = 0;
  int errors  = 0;

  // Results of the most recent run_cycle
  int            fin_cyc, pulses, fin_pulses, ones0, tail_busy;
  int            hi_min, hi_max, lo_min, lo_max;
  logic          busy_at_load, en_at_load;
  logic [NE-1:0] bitseq;

  electrode_cfg_serdes #(
    .N_ELECTRODES(31),
    .N_CH(2),
    .DIV_W(4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .start(start),
    .lsb_first(lsb_first),
    .clk_div(clk_div),
    .cfg_in(cfg_in),
    .serial_in(serial_in),
    .busy(busy),
    .enable_config(enable_config),
    .sr_clk(sr_clk),
    .serial_out(serial_out),
    .readback(readback),
    .sr_finish(sr_finish)
  );

  always #5 CLK = ~CLK;

  always_comb serial_in = {serial_out[1], chain_mode ? chain[NE-1] : serial_out[0]};

  // Electrode chain: bit NE-1 is the end of the chain feeding serial_in.
  always @(posedge sr_clk or posedge chain_load) begin
    if (chain_load) chain <= chain_init;
    else            chain <= {chain[NE-2:0], serial_out[0]};
  end

  // Runs one configuration cycle and records what the outputs did.
  task automatic run_cycle(input logic [NE-1:0] c0, input logic [NE-1:0] c1,
                           input logic lsb, input logic [3:0] d,
                           input bit chg, input bit poke);
    int   cyc, run_hi, run_lo;
    logic prev_clk;
    cfg_in = {c1, c0}; lsb_first = lsb; clk_div = d;
    fin_cyc = 0; pulses = 0; fin_pulses = 0; ones0 = 0; tail_busy = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    run_hi = 0; run_lo = 0; bitseq = '0; prev_clk = 1'b0;
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start = 1'b0; cyc = 1;
    busy_at_load = busy; en_at_load = enable_config;
    while (fin_cyc == 0 && cyc < 3000) begin
      @(negedge CLK); cyc++;
      if (chg && cyc == 10) begin
        clk_div = 4'd3; lsb_first = ~lsb; cfg_in = ~cfg_in;
      end
      if (poke && cyc == 20) start = 1'b1;
      if (poke && cyc == 21) start = 1'b0;
      if (sr_clk) run_hi++;
      else if (enable_config) run_lo++;
      if (sr_clk && !prev_clk) begin
        pulses++;
        bitseq = {bitseq[NE-2:0], serial_out[0]};
        if (run_lo < lo_min) lo_min = run_lo;
        if (run_lo > lo_max) lo_max = run_lo;
        run_lo = 0;
      end
      if (!sr_clk && prev_clk) begin
        if (run_hi < hi_min) hi_min = run_hi;
        if (run_hi > hi_max) hi_max = run_hi;
        run_hi = 0;
      end
      if (serial_out[0]) ones0++;
      if (sr_finish) begin fin_cyc = cyc; fin_pulses++; end
      prev_clk = sr_clk;
    end
    if (poke && fin_cyc != 0) start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (sr_finish) fin_pulses++;
      if (busy) tail_busy++;
    end
  endtask

  task automatic test_reset;
    vectors++;
    if ({busy, enable_config, sr_clk, sr_finish, serial_out, readback} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {busy, enable_config, sr_clk, sr_finish, serial_out, readback});
    end
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({busy, enable_config, sr_clk, sr_finish} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_idle: got %b required 0000",
               {busy, enable_config, sr_clk, sr_finish});
    end
  endtask

  task automatic test_reset_mid_shift;
    int cyc, np, fin_seen, busy_seen;
    logic prev_clk;
    cfg_in = {31'h7FFFFFFF, 31'h2AAAAAAA}; lsb_first = 1'b0; clk_div = 4'd0;
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start = 1'b0;
    cyc = 1; np = 0; prev_clk = 1'b0;
    while (np < 10 && cyc < 3000) begin
      @(negedge CLK); cyc++;
      if (sr_clk && !prev_clk) np++;
      prev_clk = sr_clk;
    end
    vectors++;
    if (np !== 10) begin
      errors++;
      $display("FAIL rst_mid_reach_bit10: got %0d pulses required 10", np);
    end
    #2 RST_N = 1'b0;
    #1;
    vectors++;
    if ({busy, enable_config, sr_clk, sr_finish, serial_out, readback} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async_clear: got %h required 0",
               {busy, enable_config, sr_clk, sr_finish, serial_out, readback});
    end
    fin_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (sr_finish) fin_seen++;
    end
    RST_N = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (sr_finish) fin_seen++;
      if (busy) busy_seen++;
    end
    vectors++;
    if (fin_seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_no_finish: got %0d pulses required 0", fin_seen);
    end
    vectors++;
    if (busy_seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_idle_after: got %0d busy cycles required 0", busy_seen);
    end
  endtask

  task automatic test_msb_first;
    chain_mode = 1'b0;
    run_cycle(31'h5A5A5A5A, 31'h7FFFFFFF, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({busy_at_load, en_at_load} !== 2'b10) begin
      errors++;
      $display("FAIL msb_load_flags: got %b required 10", {busy_at_load, en_at_load});
    end
    vectors++;
    if (bitseq !== 31'h5A5A5A5A) begin
      errors++;
      $display("FAIL msb_bit_order: got %h required 5a5a5a5a", bitseq);
    end
    vectors++;
    if (pulses !== 31) begin
      errors++;
      $display("FAIL msb_pulses: got %0d required 31", pulses);
    end
    vectors++;
    if (fin_cyc !== 64) begin
      errors++;
      $display("FAIL msb_finish_cycle: got %0d required 64", fin_cyc);
    end
    vectors++;
    if (readback !== {31'h7FFFFFFF, 31'h5A5A5A5A}) begin
      errors++;
      $display("FAIL msb_readback: got %h required %h", readback, {31'h7FFFFFFF, 31'h5A5A5A5A});
    end
    vectors++;
    if (fin_pulses !== 1) begin
      errors++;
      $display("FAIL msb_finish_pulses: got %0d required 1", fin_pulses);
    end
  endtask

  task automatic test_lsb_first;
    chain_mode = 1'b0;
    run_cycle(31'h00000001, 31'h000000FF, 1'b1, 4'd0, 1'b0, 1'b0);
    vectors++;
    if (bitseq !== 31'h40000000) begin
      errors++;
      $display("FAIL lsb_bit_order: got %h required 40000000", bitseq);
    end
    vectors++;
    if (ones0 !== 2) begin
      errors++;
      $display("FAIL lsb_first_period_only: got %0d high cycles required 2", ones0);
    end
    vectors++;
    if (readback !== {31'h000000FF, 31'h00000001}) begin
      errors++;
      $display("FAIL lsb_readback: got %h required %h", readback, {31'h000000FF, 31'h00000001});
    end
    vectors++;
    if (fin_cyc !== 64) begin
      errors++;
      $display("FAIL lsb_finish_cycle: got %0d required 64", fin_cyc);
    end
  endtask

  task automatic test_div1;
    chain_mode = 1'b0;
    run_cycle(31'h1234ABCD, 31'h00F0F0F0, 1'b0, 4'd1, 1'b1, 1'b0);
    vectors++;
    if (fin_cyc !== 126) begin
      errors++;
      $display("FAIL div1_finish_cycle: got %0d required 126", fin_cyc);
    end
    vectors++;
    if ({hi_min, hi_max, lo_min, lo_max} !== {32'd2, 32'd2, 32'd2, 32'd2}) begin
      errors++;
      $display("FAIL div1_phase_len: got hi %0d..%0d lo %0d..%0d required all 2",
               hi_min, hi_max, lo_min, lo_max);
    end
    vectors++;
    if (readback !== {31'h00F0F0F0, 31'h1234ABCD}) begin
      errors++;
      $display("FAIL div1_readback: got %h required %h", readback, {31'h00F0F0F0, 31'h1234ABCD});
    end
  endtask

  task automatic test_div_max;
    chain_mode = 1'b0;
    run_cycle(31'h00000003, 31'h40000000, 1'b0, 4'd15, 1'b0, 1'b0);
    vectors++;
    if (fin_cyc !== 994) begin
      errors++;
      $display("FAIL divmax_finish_cycle: got %0d required 994", fin_cyc);
    end
    vectors++;
    if ({hi_min, hi_max} !== {32'd16, 32'd16}) begin
      errors++;
      $display("FAIL divmax_phase_len: got %0d..%0d required 16", hi_min, hi_max);
    end
    vectors++;
    if (readback !== {31'h40000000, 31'h00000003}) begin
      errors++;
      $display("FAIL divmax_readback: got %h required %h", readback, {31'h40000000, 31'h00000003});
    end
  endtask

  task automatic test_chain;
    chain_mode = 1'b1;
    chain_init = 31'h12345678;
    chain_load = 1'b1; #1 chain_load = 1'b0;
    run_cycle(31'h0F0F1234, 31'h55555555, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if (readback[NE-1:0] !== 31'h12345678) begin
      errors++;
      $display("FAIL chain_readback: got %h required 12345678", readback[NE-1:0]);
    end
    vectors++;
    if (chain !== 31'h0F0F1234) begin
      errors++;
      $display("FAIL chain_contents: got %h required 0f0f1234", chain);
    end
    vectors++;
    if (readback[2*NE-1:NE] !== 31'h55555555) begin
      errors++;
      $display("FAIL chain_ch1_readback: got %h required 55555555", readback[2*NE-1:NE]);
    end
    chain_mode = 1'b0;
  endtask

  task automatic test_ignore_start;
    chain_mode = 1'b0;
    run_cycle(31'h00C0FFEE, 31'h00000000, 1'b0, 4'd0, 1'b0, 1'b1);
    vectors++;
    if (fin_pulses !== 1) begin
      errors++;
      $display("FAIL ignore_finish_pulses: got %0d required 1", fin_pulses);
    end
    vectors++;
    if (tail_busy !== 0) begin
      errors++;
      $display("FAIL ignore_no_retrigger: got %0d busy cycles required 0", tail_busy);
    end
    vectors++;
    if (fin_cyc !== 64) begin
      errors++;
      $display("FAIL ignore_finish_cycle: got %0d required 64", fin_cyc);
    end
    vectors++;
    if (readback[NE-1:0] !== 31'h00C0FFEE) begin
      errors++;
      $display("FAIL ignore_readback_held: got %h required 00c0ffee", readback[NE-1:0]);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, f1, f2, idle;
    chain_mode = 1'b0;
    cfg_in = {31'h0000000F, 31'h70000001}; lsb_first = 1'b0; clk_div = 4'd0;
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    cyc = 1; f1 = 0; f2 = 0; idle = 0;
    while (f2 == 0 && cyc < 3000) begin
      @(negedge CLK); cyc++;
      if (!busy) idle++;
      if (sr_finish) begin
        if (f1 == 0) f1 = cyc;
        else         f2 = cyc;
      end
    end
    start = 1'b0;
    vectors++;
    if (f1 !== 64) begin
      errors++;
      $display("FAIL b2b_first_finish: got %0d required 64", f1);
    end
    vectors++;
    if (f2 !== 129) begin
      errors++;
      $display("FAIL b2b_second_finish: got %0d required 129", f2);
    end
    vectors++;
    if (idle !== 1) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d idle cycles required 1", idle);
    end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    chain_load = 1'b1; #1 chain_load = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset;
    test_reset_mid_shift;
    test_msb_first;
    test_lsb_first;
    test_div1;
    test_div_max;
    test_chain;
    test_ignore_start;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/electrode_cfg_serdes.md
Name: electrode_cfg_serdes

Overview:
Multi-channel successor to the single-chain electrode configuration serializer. It shifts N_CH parallel electrode configuration words out to N_CH daisy-chained electrode registers over a shared, divided shift clock. It captures the bits returning from each chain as a readback word, and it supports MSB-first and LSB-first ordering. It sits between the configuration controller and the electrode array pads.

Parameters:
N_ELECTRODES, 31, bits per chain (>=2)
N_CH, 2, number of independent chains driven in lockstep
DIV_W, 4, width of clock-divider setting

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
start  in  1  request a configuration cycle; sampled only in IDLE
lsb_first  in  1  0: bit N_ELECTRODES-1 first (legacy order); 1: bit 0 first
clk_div  in  DIV_W  half-period of sr_clk in CLK cycles, minus 1 (D)
cfg_in  in  N_CH*N_ELECTRODES  channel c uses slice [c*N_ELECTRODES +: N_ELECTRODES]
serial_in  in  N_CH  bit returning from the end of each chain
busy  out  1  high from the LOAD state through the FINISH state inclusive
enable_config  out  1  high while shifting
sr_clk  out  1  shift clock to chains (registered, glitch-free)
serial_out  out  N_CH  serial data per chain
readback  out  N_CH*N_ELECTRODES  bits captured from serial_in, same slicing as cfg_in
sr_finish  out  1  one-cycle completion pulse

Behaviour:
- Reset: RST_N is asynchronous and active-low; CLK is the clock. On reset, every output and internal register clears to 0 and the FSM enters IDLE. Reset asserted mid-operation aborts the cycle immediately; no sr_finish pulse is produced.
- All outputs are registered.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE: if start=1, go to LOAD; otherwise stay in IDLE.
- LOAD (1 cycle):
  - latch cfg_in into per-channel shift registers;
  - latch clk_div as D and lsb_first as the bit order;
  - clear bit_cnt and phase_cnt;
  - go to SHIFT_LO.
  - clk_div, lsb_first and cfg_in changes after LOAD have no effect until the next cycle.
- SHIFT_LO (D+1 cycles):
  - on the entering edge, serial_out[c] takes the next bit: MSB of the shift register if msb-first, LSB if lsb-first; the register then shifts by one;
  - sr_clk=0 and enable_config=1;
  - after D+1 cycles, go to SHIFT_HI.
- SHIFT_HI (D+1 cycles):
  - on the entering edge, sr_clk rises and serial_in[c] is shifted into the readback register;
  - msb-first: readback shifts left and inserts at bit 0;
  - lsb-first: readback shifts right and inserts at bit N_ELECTRODES-1;
  - consequence: a zero-latency loopback (serial_in=serial_out) yields readback==cfg in either order;
  - after D+1 cycles: if bit_cnt==N_ELECTRODES-1, go to FINISH; otherwise increment bit_cnt and go to SHIFT_LO.
- FINISH (1 cycle):
  - sr_finish=1, enable_config=0, serial_out=0, sr_clk=0, busy=1;
  - then go to IDLE.
- readback holds its value from the end of the cycle until the next LOAD. It is not cleared in IDLE.
- Latency: with start sampled at edge 0, LOAD occupies cycle 1 and FINISH occupies cycle 2+2*N_ELECTRODES*(D+1).
  - N_ELECTRODES=31, D=0: cycle 64.
  - N_ELECTRODES=31, D=1: cycle 126.
- start while busy is ignored and is not queued. start held high continuously re-triggers in the first IDLE cycle after FINISH.
- All channels share sr_clk, state and counters; the channels differ only in data.
- D=0 gives the fastest rate, sr_clk=CLK/2. D=2^DIV_W-1 is the slowest rate and must not overflow phase_cnt.
- bit_cnt width is clog2(N_ELECTRODES). phase_cnt width is DIV_W.

Test Plan:
1. Reset mid-shift: assert RST_N=0 at the 10th bit -> all outputs 0 asynchronously, no sr_finish pulse, IDLE on release; the next start works normally.
2. N_CH=2, D=0, lsb_first=0, cfg ch0=0x5A5A5A5A&mask, ch1=0x7FFFFFFF, loopback -> serial_out ch0 bit sequence equals cfg from bit 30 down to bit 0; sr_clk has 31 pulses; sr_finish at cycle 64; readback==cfg_in.
3. lsb_first=1, D=0, cfg ch0=0x00000001 -> serial_out[0]=1 in the first bit period only; loopback readback==cfg_in.
4. D=1 -> each sr_clk phase lasts 2 CLK cycles; sr_finish at cycle 126; changing clk_div to 3 mid-cycle has no effect.
5. Chain model: a 31-bit shift register preloaded with 0x12345678 -> after the cycle, readback equals 0x12345678&mask and the chain holds the new cfg.
6. start pulsed during SHIFT and FINISH -> ignored, exactly one sr_finish pulse; start held high -> back-to-back cycles separated by exactly one IDLE cycle.
